// File: rtl/shift_rotleft_if.sv
// Valid/retry handshake bundle for the pipelined rotate-left unit.
// The producer and consumer sides share one interface; the DUT takes the slave view.
interface shift_rotleft_if #(
  parameter int Bits = 64
);
  localparam int Log = $clog2(Bits);

  logic            inp_valid;
  logic            inp_retry;
  logic [Bits-1:0] inp_a;
  logic [Log-1:0]  inp_sh;
  logic            out_valid;
  logic            out_retry;
  logic [Bits-1:0] out_b;

  modport master (
    output inp_valid, inp_a, inp_sh, out_retry,
    input  inp_retry, out_valid, out_b
  );

  modport slave (
    input  inp_valid, inp_a, inp_sh, out_retry,
    output inp_retry, out_valid, out_b
  );
endinterface

// File: rtl/shift_rotleft_pipe.sv
// Pipelined rotate-left: stage k rotates by 2^k when its shift bit is set.
// Bubble-collapsing valid/retry flow control, one result per cycle when unstalled.
module shift_rotleft_pipe #(
  parameter int Bits = 64
) (
  input  logic           clk,
  input  logic           reset,
  shift_rotleft_if.slave bus
);
  localparam int Log = $clog2(Bits);
  // The last stage has no shift bits left to carry.
  localparam int ShN = (Log > 1) ? Log - 1 : 1;

  logic [Log-1:0]  v_q;
  logic [Bits-1:0] d_q   [Log];
  logic [Log-1:0]  sh_q  [ShN];

  logic [Log-1:0]  v_in;
  logic [Bits-1:0] d_in  [Log];
  logic [Log-1:0]  sh_in [Log];
  logic [Bits-1:0] d_rot [Log];
  logic [Log-1:0]  stall;

  function automatic logic [Bits-1:0] rotl_pow2(input logic [Bits-1:0] d, input int k);
    return (d << (1 << k)) | (d >> (Bits - (1 << k)));
  endfunction

  // Stage k stalls only when it and every stage above it is valid and the
  // consumer is retrying; forcing the lower bits to 1 keeps this loop-free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    stall = '0;
    for (int k = 0; k < Log; k++) begin
      stall[k] = bus.out_retry & (&(v_q | Log'((1 << k) - 1)));
    end
  end

  always_comb begin
    v_in  = '0;
    d_in  = '{default: '0};
    sh_in = '{default: '0};
    d_rot = '{default: '0};

    v_in[0]  = bus.inp_valid;
    d_in[0]  = bus.inp_a;
    sh_in[0] = bus.inp_sh;
    for (int k = 1; k < Log; k++) begin
      v_in[k]  = v_q[k-1];
      d_in[k]  = d_q[k-1];
      sh_in[k] = sh_q[k-1];
    end

    // Remaining shift bits are kept right-aligned, so bit 0 is always this stage's.
    for (int k = 0; k < Log; k++) begin
      d_rot[k] = sh_in[k][0] ? rotl_pow2(d_in[k], k) : d_in[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      // NOTE: data registers are reset too so out_b is a clean 0 rather than X.
      for (int k = 0; k < Log; k++) d_q[k] <= '0;
      for (int k = 0; k < ShN; k++) sh_q[k] <= '0;
    end else begin
      // NOTE: non-blocking updates so every stage samples its predecessor's old value.
      for (int k = 0; k < Log; k++) begin
        if (!stall[k]) begin
          v_q[k] <= v_in[k];
          d_q[k] <= d_rot[k];
        end
      end
      for (int k = 0; k < Log - 1; k++) begin
        if (!stall[k]) sh_q[k] <= sh_in[k] >> 1;
      end
    end
  end

  assign bus.inp_retry = stall[0];
  assign bus.out_valid = v_q[Log-1];
  assign bus.out_b     = d_q[Log-1];

endmodule

// File: tb/tb_shift_rotleft_pipe.sv
// Self-checking bench for shift_rotleft_pipe: directed rotates, streaming,
// back-pressure, bubble collapse, random handshake and mid-flight reset.
module tb_shift_rotleft_pipe;
  localparam int Bits = 64;
  localparam int Log  = 6;

  logic clk = 1'b0;
  logic reset;

  shift_rotleft_if #(.Bits(Bits)) bus ();

  shift_rotleft_pipe #(.Bits(Bits)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  int          accepted = 0;
  int          retired  = 0;
  logic        last_out_valid;
  logic [63:0] last_out_b;
  logic        last_inp_retry;
  logic        last_accept;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_b    = '0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference rotate: take the upper half of the doubled word shifted left.
  function automatic logic [63:0] rotl(input logic [63:0] a, input int sh);
    logic [127:0] w;
    w = {a, a} << sh;
    return w[127:64];
  endfunction

  // One clock: observe mid-cycle, update the scoreboard, then step past the edge.
  task automatic cycle();
    @(negedge clk);
    last_out_valid = bus.out_valid;
    last_out_b     = bus.out_b;
    last_inp_retry = bus.inp_retry;
    last_accept    = 1'b0;
    if (!reset) begin
      check("inp_retry", bus.inp_retry, (exp_q.size() == Log) && bus.out_retry);
      if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_b", bus.out_b, prev_b);
      end
      if (bus.out_valid) check("valid_has_entry", exp_q.size() != 0, 1);
      if (bus.out_valid && !bus.out_retry && exp_q.size() != 0) begin
        check("data", bus.out_b, exp_q.pop_front());
        retired++;
      end
      if (bus.inp_valid && !bus.inp_retry) begin
        exp_q.push_back(rotl(bus.inp_a, int'(bus.inp_sh)));
        accepted++;
        last_accept = 1'b1;
      end
      prev_hold = bus.out_valid && bus.out_retry;
      prev_b    = bus.out_b;
    end else begin
      prev_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    bus.inp_a  = {$urandom, $urandom};
    bus.inp_sh = 6'($urandom_range(0, 63));
  endtask

  task automatic drain();
    int n;
    bus.inp_valid = 1'b0;
    bus.out_retry = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic basic_rotate(input string tag, input logic [63:0] a, input logic [5:0] sh,
                              input logic [63:0] expected);
    int n;
    bus.inp_a     = a;
    bus.inp_sh    = sh;
    bus.inp_valid = 1'b1;
    bus.out_retry = 1'b0;
    cycle();
    check({tag, "_accept"}, last_accept, 1);
    bus.inp_valid = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_out_valid && n < 20);
    check({tag, "_latency"}, n, Log);
    check({tag, "_value"}, last_out_b, expected);
    repeat (2) cycle();
  endtask

  initial begin
    int acc0, ret0, gaps;

    reset         = 1'b1;
    bus.inp_valid = 1'b1;
    bus.inp_a     = 64'hDEAD_BEEF_0000_0001;
    bus.inp_sh    = 6'd5;
    bus.out_retry = 1'b0;

    // Reset with an input presented throughout: nothing may be accepted.
    repeat (3) cycle();
    reset         = 1'b0;
    bus.inp_valid = 1'b0;
    cycle();
    check("reset_out_valid", last_out_valid, 0);
    check("reset_out_b", last_out_b, 0);
    check("reset_inp_retry", last_inp_retry, 0);
    repeat (10) cycle();
    check("reset_no_accept", accepted, 0);

    // Directed rotates on an idle pipe.
    basic_rotate("rot1",  64'h8000_0000_0000_0001, 6'd1,  64'h0000_0000_0000_0003);
    basic_rotate("rot0",  64'h8000_0000_0000_0001, 6'd0,  64'h8000_0000_0000_0001);
    basic_rotate("rot63", 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000);
    basic_rotate("rot32", 64'h0123_4567_89AB_CDEF, 6'd32, 64'h89AB_CDEF_0123_4567);

    // Streaming: back-to-back inputs, no back-pressure.
    acc0 = accepted;
    ret0 = retired;
    gaps = 0;
    bus.out_retry = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive_random();
      bus.inp_valid = 1'b1;
      cycle();
      if (i >= Log && !last_out_valid) gaps++;
    end
    check("stream_accepts", accepted - acc0, 256);
    check("stream_gaps", gaps, 0);
    drain();
    check("stream_retired", retired - ret0, 256);

    // Back-pressure fill: exactly Log entries fit before retry.
    acc0 = accepted;
    bus.out_retry = 1'b1;
    bus.inp_valid = 1'b1;
    drive_random();
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_accept) drive_random();
    end
    check("fill_accepts", accepted - acc0, Log);
    check("fill_retry", last_inp_retry, 1);
    check("fill_out_valid", last_out_valid, 1);
    drain();

    // Bubble collapse: alternating valid under retry still fills all stages.
    acc0 = accepted;
    bus.out_retry = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.inp_valid = (i % 2 == 0);
      if (bus.inp_valid) drive_random();
      cycle();
    end
    check("bubble_accepts", accepted - acc0, Log);
    bus.inp_valid = 1'b1;
    drive_random();
    cycle();
    check("bubble_retry", last_inp_retry, 1);
    check("bubble_no_extra", last_accept, 0);
    drain();

    // Random handshake; a retried producer holds its transaction.
    acc0 = accepted;
    bus.inp_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(bus.inp_valid && !last_accept)) begin
        bus.inp_valid = $urandom_range(0, 1) != 0;
        drive_random();
      end
      bus.out_retry = $urandom_range(0, 1) != 0;
      cycle();
    end
    check("random_activity", (accepted - acc0) > 1000, 1);
    drain();

    // Reset with four transactions in flight.
    bus.out_retry = 1'b0;
    bus.inp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_random();
      cycle();
    end
    check("flight_count", exp_q.size(), 4);
    bus.inp_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    cycle();
    check("midreset_out_valid", last_out_valid, 0);
    check("midreset_out_b", last_out_b, 0);
    ret0 = retired;
    repeat (12) cycle();
    check("midreset_no_stale", retired - ret0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/shift_rotleft_pipe.md
# shift_rotleft_pipe

Pipelined rotate-left unit: accepts a `Bits`-wide word and a rotate amount, returns the word rotated left by that amount after a fixed pipeline latency. It complements the combinational rotate-right barrel shifter in the same `ware/rtl` shift library. It is intended for datapaths that need rotate-left at high clock rates, where a single-cycle `Bits`-way mux is too slow. It uses a valid/retry handshake on both sides and sustains one result per cycle.

## Interface
- `Bits`, 64, data width; must be a power of two and at least 2.
- `Log`, `log2(Bits)`, number of pipeline stages and width of `inp_sh`; derived, never overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; one clock domain, reset is synchronous and active-high.
- `inp_valid`  in  1  input transaction present.
- `inp_retry`  out  1  input not accepted this cycle; the producer must hold `inp_a` and `inp_sh`.
- `inp_a`  in  `Bits`  word to rotate.
- `inp_sh`  in  `Log`  left-rotate amount, 0..`Bits`-1.
- `out_valid`  out  1  result present.
- `out_retry`  in  1  consumer cannot take the result this cycle.
- `out_b`  out  `Bits`  `inp_a` rotated left by `inp_sh`.

## Operation
- The pipeline has `Log` register stages, S0..S(`Log`-1). Each stage holds:
  - a valid bit;
  - a `Bits` data word;
  - the remaining shift bits.
- Stage k rotates its incoming data left by 2^k when shift bit k is 1. Otherwise it passes the data through unchanged.
  - S0 takes its input from `inp_a` and `inp_sh`.
  - Stage k takes its input from stage k-1.
- Shift bits already consumed need not be carried forward. Only bits k..`Log`-1 travel with the data.
- A rotate is exact modulo `Bits`:
  - bits shifted out of the MSB re-enter at the LSB;
  - no bit is lost or zero-filled;
  - `inp_sh`=0 returns `inp_a` unchanged.
- `out_valid`/`out_b` are driven directly from the S(`Log`-1) registers.
- Flow control is bubble-collapsing:
  - Stage k is stalled when it is valid and stage k+1 is stalled. The last stage is stalled when `out_valid` and `out_retry` are both 1.
  - A non-stalled stage loads from its predecessor every cycle. It loads valid=0 when the predecessor is empty or the input is not presented.
  - A stalled stage holds its valid bit, data and shift bits unchanged.
- `inp_retry` = S0 valid AND S0 stalled. It is a combinational function of the stage valids and `out_retry`.
- An input is accepted in a cycle with `inp_valid`=1 and `inp_retry`=0.
- When `inp_retry`=1, the producer holds its inputs stable. The block does not sample `inp_a`/`inp_sh` that cycle.
- Ordering is strictly FIFO. There is no reordering, dropping or duplication.

## Timing
- Latency: an input accepted at edge N appears on `out_valid`/`out_b` after edge N+`Log`-1, given no stalls. For `Bits`=64 that is 6 stages, so the result is visible in the 6th cycle after presentation.
- Throughput: one accept per cycle while `out_retry`=0.
- Back-pressure:
  - With `out_retry` held at 1, the pipe absorbs inputs until all `Log` stages are valid. Only then does `inp_retry` assert.
  - Bubbles are squeezed out before retry reaches the input.
- Retry release: the cycle `out_retry` falls with a full pipe, `inp_retry` falls in the same cycle. That cycle both accepts an input and retires an output.
- `out_b` is stable while `out_valid`=1 and `out_retry`=1.
- When `out_valid`=0, `out_b` is don't-care but must not be X after reset. Data registers reset to 0.
- Reset values:
  - all stage valids 0;
  - data and shift registers 0;
  - `out_valid`=0, `out_b`=0;
  - `inp_retry`=0.
- Reset mid-operation: all in-flight transactions are discarded at the reset edge. No output appears for them after reset deasserts.
- An input presented while `reset`=1 is not accepted.

## Test plan
- Basic rotates (`Bits`=64), each on an idle pipe:
  - `inp_a`=0x8000_0000_0000_0001, `inp_sh`=1 -> `out_b`=0x0000_0000_0000_0003, `out_valid` exactly 6 cycles after acceptance;
  - `inp_sh`=0 -> `out_b`=0x8000_0000_0000_0001;
  - `inp_a`=0x1, `inp_sh`=63 -> 0x8000_0000_0000_0000.
- Streaming: 256 back-to-back random (`inp_a`, `inp_sh`) with `out_retry`=0 -> `inp_retry` never asserts, and outputs match a rotl reference model in order, one per cycle.
- Back-pressure fill:
  - hold `out_retry`=1 and present inputs each cycle -> exactly 6 accepted, then `inp_retry`=1 and `out_b` stable;
  - drop `out_retry` -> all drain in order with no loss or duplication.
- Bubble collapse: alternate `inp_valid` 1/0 while `out_retry`=1 for 12 cycles -> 6 entries accepted before `inp_retry` asserts.
- Random `out_retry` (50%) and `inp_valid` (50%) for 10k cycles -> scoreboard match with no drops, plus the assertions "`out_b` stable under retry" and "`inp_retry` implies all stages valid".
- Reset with 4 transactions in flight -> `out_valid`=0 and `out_b`=0 the cycle after reset, and no stale result emerges later.
